// File: rtl/csa_sub_pkg.sv
// Shared types and default geometry for the sequential carry-select subtractor.
package csa_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLK   = 4;

endpackage

// File: rtl/csa_sub_seq_if.sv
// Operand/result handshake bundle for csa_sub_seq; master = requester, slave = subtractor.
interface csa_sub_seq_if #(
  parameter int WIDTH = csa_sub_pkg::DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] i_sub_term1;
  logic [WIDTH-1:0] i_sub_term2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  modport master (
    output in_valid, i_sub_term1, i_sub_term2, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf
  );

  modport slave (
    input  in_valid, i_sub_term1, i_sub_term2, out_ready,
    output in_ready, out_valid, diff, borrow, ovf
  );
endinterface

// File: rtl/csa_sel_block.sv
// One BLK-bit carry-select slice: both carry-in cases are summed, cin picks one.
module csa_sel_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout
);
  logic [BLK:0] sum_c0;
  logic [BLK:0] sum_c1;

  assign sum_c0      = {1'b0, a} + {1'b0, b};
  assign sum_c1      = {1'b0, a} + {1'b0, b} + (BLK+1)'(1);
  assign {cout, sum} = cin ? sum_c1 : sum_c0;
endmodule

// File: rtl/csa_sub_seq.sv
// Sequential subtractor: a - b = a + ~b + 1, one carry-select block per RUN cycle.
// Optional signed-overflow flag built only when CSA_SUB_OVF_EN is defined.
module csa_sub_seq
  import csa_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLK   = DEF_BLK
) (
  input  logic         clk,
  input  logic         rst_n,
  csa_sub_seq_if.slave bus
);
  localparam int N     = WIDTH / BLK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH % BLK != 0) begin : g_bad_geometry
      $error("csa_sub_seq: WIDTH must be a multiple of BLK");
    end
  endgenerate

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] bn_r;
  logic [WIDTH-1:0] diff_r;
  logic             carry_r;
  logic             borrow_r;
  logic [IDX_W-1:0] idx;
  logic [BLK-1:0]   a_blk, b_blk, sum_blk;
  logic             cout_blk;
  logic             last_blk;
  logic             accept;

  assign accept   = (state == IDLE) && bus.in_valid;
  assign last_blk = (idx == IDX_W'(N - 1));
  assign a_blk    = a_r[int'(idx)*BLK +: BLK];
  assign b_blk    = bn_r[int'(idx)*BLK +: BLK];

  // single slice shared across all block positions, selected by idx
  csa_sel_block #(.BLK(BLK)) u_sel (
    .a    (a_blk),
    .b    (b_blk),
    .cin  (carry_r),
    .sum  (sum_blk),
    .cout (cout_blk)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_blk)      state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r      <= '0;
      bn_r     <= '0;
      diff_r   <= '0;
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
      idx      <= '0;
    end else if (accept) begin
      a_r      <= bus.i_sub_term1;
      bn_r     <= ~bus.i_sub_term2;
      diff_r   <= '0;
      carry_r  <= 1'b1;
      borrow_r <= 1'b0;
      idx      <= '0;
    end else if (state == RUN) begin
      diff_r[int'(idx)*BLK +: BLK] <= sum_blk;
      carry_r                      <= cout_blk;
      idx                          <= idx + 1'b1;
      if (last_blk) borrow_r <= ~cout_blk;
    end
  end

`ifdef CSA_SUB_OVF_EN
  logic ovf_r;
  logic msb_cin;

  // carry into the MSB recovered from the MSB sum bit and its operands
  assign msb_cin = a_blk[BLK-1] ^ b_blk[BLK-1] ^ sum_blk[BLK-1];

  always_ff @(posedge clk) begin
    if (!rst_n)                          ovf_r <= 1'b0;
    else if (accept)                     ovf_r <= 1'b0;
    else if ((state == RUN) && last_blk) ovf_r <= msb_cin ^ cout_blk;
  end

  assign bus.ovf = ovf_r;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff_r;
  assign bus.borrow    = borrow_r;
endmodule

// File: tb/tb_csa_sub_seq.sv
// Directed bench for csa_sub_seq at WIDTH=16, BLK=4 with an arithmetic reference model.
module tb_csa_sub_seq;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         o;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;
  int   acc_n = 0;
  int   last_acc = 0;
  bit   b2b = 1'b0;
  bit   have_last = 1'b0;
  bit   prev_ov = 1'b0;
  exp_t q[$];

`ifdef CSA_SUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  csa_sub_seq_if #(.WIDTH(W)) bus ();

  csa_sub_seq #(.WIDTH(W), .BLK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Plain integer arithmetic: unsigned compare for borrow, signed range for overflow
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
    exp_t e;
    int sd;
    sd    = int'($signed(a)) - int'($signed(b));
    e.d   = a - b;
    e.b   = (a < b);
    e.o   = OVF_ON && ((sd > 32767) || (sd < -32768));
    e.acc = c;
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.i_sub_term1, bus.i_sub_term2, cyc));
        acc_n++;
        if (b2b && have_last) check("b2b_spacing", 32'(cyc - last_acc), 32'd6);
        have_last = b2b;
        last_acc  = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        check("model_diff",   32'(bus.diff),   32'(q[0].d));
        check("model_borrow", 32'(bus.borrow), 32'(q[0].b));
        check("model_ovf",    32'(bus.ovf),    32'(q[0].o));
        if (!prev_ov) check("latency", 32'(cyc - q[0].acc), 32'd4);
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ed, input logic eb, input logic eo);
    int n = 0;
    wait_ready();
    bus.i_sub_term1 = a;
    bus.i_sub_term2 = b;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.i_sub_term1 = 16'($urandom);
    bus.i_sub_term2 = 16'($urandom);
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    check({nm, "_valid"},  32'(bus.out_valid), 32'd1);
    check({nm, "_diff"},   32'(bus.diff),      32'(ed));
    check({nm, "_borrow"}, 32'(bus.borrow),    32'(eb));
    check({nm, "_ovf"},    32'(bus.ovf),       32'(eo));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({nm, "_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cmp=%0d", cmp_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.i_sub_term1 = '0;
    bus.i_sub_term2 = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff",      32'(bus.diff),      32'd0);
    check("rst_borrow",    32'(bus.borrow),    32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    txn("sub_5_3",     16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
    txn("sub_3_5",     16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0);
    txn("sub_8000_1",  16'h8000, 16'h0001, 16'h7FFF, 1'b0, OVF_ON);
    txn("sub_equal",   16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0);
    txn("sub_zero",    16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0);
    txn("sub_7fff_m1", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, OVF_ON);

    // Hold in DONE while the requester keeps offering new operands
    wait_ready();
    bus.i_sub_term1 = 16'h00FF;
    bus.i_sub_term2 = 16'h0F00;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    bus.in_valid    = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid    = ~bus.in_valid;
      bus.i_sub_term1 = 16'($urandom);
      bus.i_sub_term2 = 16'($urandom);
      @(negedge clk);
      check("hold_valid",    32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready),  32'd0);
      check("hold_diff",     32'(bus.diff),      32'h0000F1FF);
      check("hold_borrow",   32'(bus.borrow),    32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hold_release_idle",  32'(bus.in_ready),  32'd1);
    check("hold_release_valid", 32'(bus.out_valid), 32'd0);

    // Reset during the second RUN cycle aborts the operation
    bus.i_sub_term1 = 16'hFFFF;
    bus.i_sub_term2 = 16'h0001;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_diff",      32'(bus.diff),      32'd0);
    check("abort_borrow",    32'(bus.borrow),    32'd0);
    repeat (6) @(negedge clk);
    txn("after_abort", 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0);

    // Back-to-back random operands with the consumer always ready
    bus.out_ready = 1'b1;
    b2b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int base = acc_n;
      n = 0;
      bus.i_sub_term1 = 16'($urandom);
      bus.i_sub_term2 = 16'($urandom);
      bus.in_valid    = 1'b1;
      while (acc_n == base && n < 20) begin @(negedge clk); n++; end
      if (acc_n == base) check("b2b_accept_timeout", 32'd0, 32'd1);
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 20) begin @(negedge clk); n++; end
    check("b2b_drained", 32'(q.size()), 32'd0);
    b2b = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/csa_sub_seq.md
CSA_SUB_SEQ -- requirements
Module: csa_sub_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 The block SHALL have parameter BLK, default 4: carry-select block width; WIDTH SHALL be a multiple of BLK, otherwise elaboration SHALL fail.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  block accepts an operand pair.
REQ-008 i_sub_term1  input  WIDTH  minuend.
REQ-009 i_sub_term2  input  WIDTH  subtrahend.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 diff  output  WIDTH  i_sub_term1 - i_sub_term2, modulo 2^WIDTH.
REQ-013 borrow  output  1  set when the minuend is less than the subtrahend, unsigned.
REQ-014 ovf  output  1  signed overflow flag (see Configuration).

Function
REQ-015 The block SHALL be an FSM with states IDLE, RUN and DONE; the number of blocks N SHALL equal WIDTH/BLK.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 In IDLE, an edge with in_valid=1 SHALL capture the minuend and the bitwise inverse of the subtrahend, set the running carry to 1, clear the block index and the diff register, and go to RUN.
REQ-018 Each RUN cycle SHALL process block k (bits k*BLK .. k*BLK+BLK-1), in order from LSB block 0.
REQ-019 Each block SHALL precompute sums for carry-in 0 and carry-in 1, then select one using the registered carry.
REQ-020 Each RUN cycle SHALL write the selected slice into diff and register the selected carry-out.
REQ-021 After block N-1, the FSM SHALL enter DONE; latency from the accept edge to out_valid=1 SHALL be exactly N cycles (4 at defaults).
REQ-022 borrow SHALL equal the inverse of the final carry-out.
REQ-023 diff, borrow and ovf SHALL be registered and SHALL be held stable while in DONE.
REQ-024 In DONE, out_valid SHALL be held until out_ready=1; on that edge the FSM SHALL return to IDLE, and the next accept SHALL be possible one cycle later.
REQ-025 in_valid SHALL be ignored outside IDLE, and operands presented then SHALL NOT be captured.
REQ-026 Input changes after the accept edge SHALL NOT affect the result.
REQ-027 Equal operands SHALL produce diff=0, borrow=0; subtrahend 0 SHALL produce diff equal to the minuend, borrow=0.

Reset
REQ-028 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE and all registers SHALL clear: diff=0, borrow=0, ovf=0, out_valid=0, in_ready=1 from the next cycle.
REQ-029 A reset asserted during RUN or DONE SHALL abort the operation, and the partial result SHALL NOT be presented.

Configuration
REQ-030 With macro CSA_SUB_OVF_EN defined, ovf SHALL equal the XOR of the carry-in and the carry-out of the MSB bit, registered alongside borrow.
REQ-031 Without CSA_SUB_OVF_EN, ovf SHALL be tied to 0 and no overflow logic SHALL be built; the port list SHALL be unchanged.

Structure
REQ-032 Package csa_sub_pkg SHALL hold the state enumeration (IDLE/RUN/DONE) and the default WIDTH/BLK constants.
REQ-033 Sub-module csa_sel_block SHALL be combinational and BLK-bit wide: inputs a, b and cin; outputs sum and cout; it SHALL compute both carry cases internally and select on cin.
REQ-034 csa_sel_block SHALL be instantiated once and time-multiplexed across the blocks by the index.

Verification (WIDTH=16, BLK=4)
REQ-035 Accept 0x0005 - 0x0003 -> out_valid exactly 4 cycles after the accept, diff=0x0002, borrow=0, ovf=0.
REQ-036 Accept 0x0003 - 0x0005 -> diff=0xFFFE, borrow=1, ovf=0.
REQ-037 Accept 0x8000 - 0x0001 -> diff=0x7FFF, borrow=0; ovf=1 with CSA_SUB_OVF_EN defined, ovf=0 without it.
REQ-038 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> result stable, in_ready=0, no capture; out_ready=1 -> IDLE on the next cycle.
REQ-039 Assert rst_n=0 for one cycle in the 2nd RUN cycle of 0xFFFF - 0x0001 -> next cycle IDLE, out_valid=0, diff=0; a subsequent 0x1234 - 0x1234 gives diff=0x0000, borrow=0.
REQ-040 Issue 20 back-to-back random pairs with out_ready=1 -> every result matches the reference model for diff, borrow and ovf, with 6-cycle accept-to-accept spacing.
